oc8051_tc_multi: RTL

//  Parametrised NCH-channel 16-bit timer/counter for the oc8051 SFR space.
//  - Per channel: free-run, auto-reload, capture or compare mode; clock prescaler; external-count and gate inputs.
//  - Sits beside the SFR mux; registers are read/written through the SFR wr/rd address bus.
//  - Flags drive the interrupt controller.

---
 rtl/oc8051_tc_multi.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/oc8051_tc_multi.sv
// oc8051_tc_multi
//   NCH-channel 16-bit timer/counter that sits in the oc8051 SFR space.
//   Each channel supports four modes: free-run, auto-reload, capture and
//   compare. Each channel also has RUN and GATE controls, and selects its
//   count source with CT: either the shared prescaler or the falling edge
//   of its t_in pin.
//
//   Register window per channel c, at BASE + 8*c:
//     +0 CTRL   {1'b0, CF, TF, RUN, GATE, CT, MODE[1:0]}
//     +1 CNT_LO  +2 CNT_HI  +3 RLD_LO  +4 RLD_HI  +5..+7 read as 0
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   wr_addr, data_in, wr  SFR byte write (qualified by wr_bit == 0)
//   wr_bit                bit-write qualifier, blocks byte writes when 1
//   rd_addr               SFR read address
//   t_in[NCH]             external count inputs (falling edge counts)
//   gate_in[NCH]          gate inputs (used when GATE = 1)
//   cap_in[NCH]           capture inputs (falling edge captures)
//   data_out, rd_hit      registered read data / address-decoded flag
//   tf[NCH], cf[NCH]      overflow/compare and capture flags
module oc8051_tc_multi #(
  parameter int         NCH     = 2,
  parameter logic [7:0] BASE    = 8'hC0,
  parameter int         PRESC_W = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     wr_addr,
  input  logic [7:0]     rd_addr,
  input  logic [7:0]     data_in,
  input  logic           wr,
  input  logic           wr_bit,
  input  logic [NCH-1:0] t_in,
  input  logic [NCH-1:0] gate_in,
  input  logic [NCH-1:0] cap_in,
  output logic [7:0]     data_out,
  output logic           rd_hit,
  output logic [NCH-1:0] tf,
  output logic [NCH-1:0] cf
);

  localparam int PW = (PRESC_W > 0) ? PRESC_W : 1;

  localparam logic [1:0] MODE_FREE = 2'b00;
  localparam logic [1:0] MODE_RLD  = 2'b01;
  localparam logic [1:0] MODE_CAP  = 2'b10;
  localparam logic [1:0] MODE_CMP  = 2'b11;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_CNT_LO = 3'd1;
  localparam logic [2:0] OFF_CNT_HI = 3'd2;
  localparam logic [2:0] OFF_RLD_LO = 3'd3;
  localparam logic [2:0] OFF_RLD_HI = 3'd4;

  logic [NCH-1:0][4:0]  ctrl_q, ctrl_d;
  logic [NCH-1:0][15:0] cnt_q, cnt_d;
  logic [NCH-1:0][15:0] rld_q, rld_d;
  logic [NCH-1:0]       tf_q, tf_d;
  logic [NCH-1:0]       cf_q, cf_d;
  logic [NCH-1:0]       t_buf_q, t_buf_d;
  logic [NCH-1:0]       cap_buf_q, cap_buf_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [7:0]           data_out_q, data_out_d;
  logic                 rd_hit_q, rd_hit_d;

  logic                 presc_stb;
  logic [NCH-1:0]       t_fall;
  logic [NCH-1:0]       cap_fall;
  logic [NCH-1:0]       inc;
  logic [NCH-1:0]       tf_set;
  logic [NCH-1:0]       cf_set;
  logic [NCH-1:0]       wr_sel;

  logic                 wr_en;
  logic                 wr_blk;
  logic [1:0]           wr_ch;
  logic [2:0]           wr_off;
  logic                 rd_blk;
  logic [1:0]           rd_ch;
  logic [2:0]           rd_off;
  logic                 rd_valid;

  // True when a 2-bit channel index names an implemented channel.
  function automatic logic ch_exists(input logic [1:0] ch);
    return ({1'b0, ch} < 3'(NCH));
  endfunction

  // Address split: window select [7:5], channel [4:3], register offset [2:0].
  always_comb begin
    wr_en    = wr & ~wr_bit;
    wr_blk   = (wr_addr[7:5] == BASE[7:5]);
    wr_ch    = wr_addr[4:3];
    wr_off   = wr_addr[2:0];
    rd_blk   = (rd_addr[7:5] == BASE[7:5]);
    rd_ch    = rd_addr[4:3];
    rd_off   = rd_addr[2:0];
    rd_valid = rd_blk & ch_exists(rd_ch);
  end

  // Free-running divider shared by all channels. With PRESC_W = 0 it
  // strobes every cycle and the counter stays at zero.
  always_comb begin
    if (PRESC_W == 0) begin
      presc_d   = '0;
      presc_stb = 1'b1;
    end else begin
      presc_d   = presc_q + 1'b1;
      presc_stb = (presc_q == {PW{1'b1}});
    end
  end

  // Edge detection: the buffered value is last cycle's pin level.
  always_comb begin
    t_buf_d   = t_in;
    cap_buf_d = cap_in;
    t_fall    = t_buf_q & ~t_in;
    cap_fall  = cap_buf_q & ~cap_in;
  end

  // Per-channel counting, register writes and flag update.
  always_comb begin
    ctrl_d = ctrl_q;
    cnt_d  = cnt_q;
    rld_d  = rld_q;
    tf_d   = tf_q;
    cf_d   = cf_q;
    inc    = '0;
    tf_set = '0;
    cf_set = '0;
    wr_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      wr_sel[c] = wr_en & wr_blk & (wr_ch == 2'(c));

      // CTRL bit 4 = RUN, 3 = GATE, 2 = CT.
      inc[c] = ctrl_q[c][4] & (~ctrl_q[c][3] | gate_in[c]) &
               (ctrl_q[c][2] ? t_fall[c] : presc_stb);

      if (inc[c]) begin
        unique case (ctrl_q[c][1:0])
          MODE_FREE, MODE_CAP: begin
            cnt_d[c]  = cnt_q[c] + 16'd1;
            tf_set[c] = (cnt_q[c] == 16'hFFFF);
          end
          MODE_RLD: begin
            if (cnt_q[c] == 16'hFFFF) begin
              cnt_d[c]  = rld_q[c];
              tf_set[c] = 1'b1;
            end else begin
              cnt_d[c] = cnt_q[c] + 16'd1;
            end
          end
          MODE_CMP: begin
            if (cnt_q[c] == rld_q[c]) begin
              cnt_d[c]  = 16'h0000;
              tf_set[c] = 1'b1;
            end else begin
              cnt_d[c] = cnt_q[c] + 16'd1;
            end
          end
          default: cnt_d[c] = cnt_q[c];
        endcase
      end

      // A software write to either count byte cancels the tick entirely:
      // the written byte loads, the other byte holds, and no TF is raised.
      if (wr_sel[c] && wr_off == OFF_CNT_LO) begin
        cnt_d[c]  = {cnt_q[c][15:8], data_in};
        tf_set[c] = 1'b0;
      end
      if (wr_sel[c] && wr_off == OFF_CNT_HI) begin
        cnt_d[c]  = {data_in, cnt_q[c][7:0]};
        tf_set[c] = 1'b0;
      end

      if (wr_sel[c] && wr_off == OFF_RLD_LO) rld_d[c][7:0]  = data_in;
      if (wr_sel[c] && wr_off == OFF_RLD_HI) rld_d[c][15:8] = data_in;

      // Capture ignores RUN and overrides a same-cycle RLD write; it
      // takes the count as it stood before this cycle's increment.
      if (ctrl_q[c][1:0] == MODE_CAP && cap_fall[c]) begin
        rld_d[c]  = cnt_q[c];
        cf_set[c] = 1'b1;
      end

      // Flags are write-0-to-clear; a hardware set in the same cycle wins.
      if (wr_sel[c] && wr_off == OFF_CTRL) begin
        ctrl_d[c] = data_in[4:0];
        if (!data_in[5]) tf_d[c] = 1'b0;
        if (!data_in[6]) cf_d[c] = 1'b0;
      end
      if (tf_set[c]) tf_d[c] = 1'b1;
      if (cf_set[c]) cf_d[c] = 1'b1;
    end
  end

  // Read mux. Count and reload bytes bypass a same-cycle write to the same
  // address. CTRL reads the pre-write state, so software sees the flags as
  // they were before its own clear.
  always_comb begin
    data_out_d = 8'h00;
    rd_hit_d   = rd_valid;
    if (rd_valid) begin
      for (int c = 0; c < NCH; c++) begin
        if (rd_ch == 2'(c)) begin
          unique case (rd_off)
            OFF_CTRL:   data_out_d = {1'b0, cf_q[c], tf_q[c], ctrl_q[c]};
            OFF_CNT_LO: data_out_d = cnt_q[c][7:0];
            OFF_CNT_HI: data_out_d = cnt_q[c][15:8];
            OFF_RLD_LO: data_out_d = rld_q[c][7:0];
            OFF_RLD_HI: data_out_d = rld_q[c][15:8];
            default:    data_out_d = 8'h00;
          endcase
        end
      end
      if (wr_en && wr_addr == rd_addr &&
          rd_off >= OFF_CNT_LO && rd_off <= OFF_RLD_HI) begin
        data_out_d = data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      cnt_q      <= '0;
      rld_q      <= '0;
      tf_q       <= '0;
      cf_q       <= '0;
      t_buf_q    <= '0;
      cap_buf_q  <= '0;
      presc_q    <= '0;
      data_out_q <= 8'h00;
      rd_hit_q   <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
      rld_q      <= rld_d;
      tf_q       <= tf_d;
      cf_q       <= cf_d;
      t_buf_q    <= t_buf_d;
      cap_buf_q  <= cap_buf_d;
      presc_q    <= presc_d;
      data_out_q <= data_out_d;
      rd_hit_q   <= rd_hit_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_hit   = rd_hit_q;
  assign tf       = tf_q;
  assign cf       = cf_q;

endmodule
